// File: rtl/instr_encoder_pkg.sv
// Shared MIPS encoding constants and helpers for instr_encoder and its bench.
// Opcode and funct values match the single-cycle core's main and ALU decoders.
package instr_enc_pkg;

   typedef enum logic [3:0] {
      KIND_ADD, KIND_SUB, KIND_AND, KIND_OR, KIND_SLT,
      KIND_ADDI, KIND_ANDI, KIND_ORI, KIND_SLTI,
      KIND_LW, KIND_SW, KIND_BEQ, KIND_BNE, KIND_J
   } kind_e;

   typedef struct packed {
      logic [3:0]  kind;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [15:0] imm;
      logic [25:0] target;
   } req_t;

   localparam logic [5:0] OPC_RTYPE = 6'b000000;
   localparam logic [5:0] OPC_ADDI  = 6'b001000;
   localparam logic [5:0] OPC_ANDI  = 6'b001100;
   localparam logic [5:0] OPC_ORI   = 6'b001101;
   localparam logic [5:0] OPC_SLTI  = 6'b001010;
   localparam logic [5:0] OPC_LW    = 6'b100011;
   localparam logic [5:0] OPC_SW    = 6'b101011;
   localparam logic [5:0] OPC_BEQ   = 6'b000100;
   localparam logic [5:0] OPC_BNE   = 6'b000101;
   localparam logic [5:0] OPC_J     = 6'b000010;

   localparam logic [5:0] FUNCT_ADD = 6'b100000;
   localparam logic [5:0] FUNCT_SUB = 6'b100010;
   localparam logic [5:0] FUNCT_AND = 6'b100100;
   localparam logic [5:0] FUNCT_OR  = 6'b100101;
   localparam logic [5:0] FUNCT_SLT = 6'b101010;

   function automatic logic kind_legal(input logic [3:0] kind);
      return kind <= KIND_J;
   endfunction

   function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] funct);
      return {OPC_RTYPE, rs, rt, rd, 5'd0, funct};
   endfunction

   function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   // Illegal kinds encode to zero; the caller is expected to drop them.
   function automatic logic [31:0] encode(input req_t r);
      logic [31:0] w;
      w = '0;
      case (r.kind)
         KIND_ADD:  w = rtype(r.rs, r.rt, r.rd, FUNCT_ADD);
         KIND_SUB:  w = rtype(r.rs, r.rt, r.rd, FUNCT_SUB);
         KIND_AND:  w = rtype(r.rs, r.rt, r.rd, FUNCT_AND);
         KIND_OR:   w = rtype(r.rs, r.rt, r.rd, FUNCT_OR);
         KIND_SLT:  w = rtype(r.rs, r.rt, r.rd, FUNCT_SLT);
         KIND_ADDI: w = itype(OPC_ADDI, r.rs, r.rt, r.imm);
         KIND_ANDI: w = itype(OPC_ANDI, r.rs, r.rt, r.imm);
         KIND_ORI:  w = itype(OPC_ORI,  r.rs, r.rt, r.imm);
         KIND_SLTI: w = itype(OPC_SLTI, r.rs, r.rt, r.imm);
         KIND_LW:   w = itype(OPC_LW,   r.rs, r.rt, r.imm);
         KIND_SW:   w = itype(OPC_SW,   r.rs, r.rt, r.imm);
         KIND_BEQ:  w = itype(OPC_BEQ,  r.rs, r.rt, r.imm);
         KIND_BNE:  w = itype(OPC_BNE,  r.rs, r.rt, r.imm);
         KIND_J:    w = {OPC_J, r.target};
         default:   w = '0;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Request side (symbolic instruction in) and imem write side (encoded word out).
// slave is the encoder's view; master is the producer / instruction-memory view.
interface instr_encoder_if #(parameter int ADDR_W = 6);
   logic              in_valid;
   logic              in_ready;
   logic [3:0]        in_kind;
   logic [4:0]        in_rs;
   logic [4:0]        in_rt;
   logic [4:0]        in_rd;
   logic [15:0]       in_imm;
   logic [25:0]       in_target;
   logic              im_we;
   logic              im_ready;
   logic [ADDR_W-1:0] im_addr;
   logic [31:0]       im_wdata;

   modport slave (
      input  in_valid, in_kind, in_rs, in_rt, in_rd, in_imm, in_target, im_ready,
      output in_ready, im_we, im_addr, im_wdata
   );

   modport master (
      output in_valid, in_kind, in_rs, in_rt, in_rd, in_imm, in_target, im_ready,
      input  in_ready, im_we, im_addr, im_wdata
   );
endinterface

// File: rtl/instr_encoder_fifo.sv
// enc_fifo: synchronous FIFO, DEPTH x W; write visible at head one cycle later.
// Registered full/empty: a pop never frees a slot for a push in the same cycle.
module enc_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clear,
   input  logic                     push,
   input  logic [W-1:0]             push_dat,
   input  logic                     pop,
   output logic [W-1:0]             pop_dat,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] cnt_q, cnt_nxt;
   logic          full_q, empty_q;
   logic          do_push, do_pop;

   assign do_push = push & ~full_q & ~clear;
   assign do_pop  = pop & ~empty_q & ~clear;

   always_comb begin
      cnt_nxt = cnt_q;
      if (clear)
         cnt_nxt = '0;
      else if (do_push && !do_pop)
         cnt_nxt = cnt_q + CW'(1);
      else if (do_pop && !do_push)
         cnt_nxt = cnt_q - CW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         cnt_q   <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
      end else begin
         if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         end
         cnt_q   <= cnt_nxt;
         full_q  <= (cnt_nxt == CW'(DEPTH));
         empty_q <= (cnt_nxt == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_dat;
   end

   // Storage is not reset, so the head is masked to zero while empty.
   assign pop_dat = empty_q ? '0 : mem[rd_ptr];
   assign full    = full_q;
   assign empty   = empty_q;
   assign count   = cnt_q;
endmodule

// File: rtl/instr_encoder.sv
// Packs symbolic instruction requests into MIPS words and streams them to imem.
// Latency: accepted word reaches im_wdata one cycle later; in_ready drops when FIFO full.
module instr_encoder
   import instr_enc_pkg::*;
#(
   parameter int DEPTH     = 4,
   parameter int ADDR_W    = 6,
   parameter int BASE_ADDR = 0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   clear,
   instr_encoder_if.slave         bus,
   output logic [$clog2(DEPTH):0] count,
   output logic                   err
);
   localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

   req_t              req;
   logic [31:0]       word;
   logic              legal;
   logic              accept;
   logic              pop;
   logic              full, empty;
   logic [ADDR_W-1:0] addr_q;
   logic              err_q;

   always_comb begin
      req.kind   = bus.in_kind;
      req.rs     = bus.in_rs;
      req.rt     = bus.in_rt;
      req.rd     = bus.in_rd;
      req.imm    = bus.in_imm;
      req.target = bus.in_target;
   end

   assign word   = encode(req);
   assign legal  = kind_legal(bus.in_kind);
   // Illegal requests still complete the handshake; they just never enter the FIFO.
   assign accept = bus.in_valid & bus.in_ready & ~clear;
   assign pop    = bus.im_we & bus.im_ready;

   enc_fifo #(.DEPTH(DEPTH), .W(32)) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (clear),
      .push     (accept & legal),
      .push_dat (word),
      .pop      (pop),
      .pop_dat  (bus.im_wdata),
      .full     (full),
      .empty    (empty),
      .count    (count)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q <= BASE;
         err_q  <= 1'b0;
      end else if (clear) begin
         addr_q <= BASE;
         err_q  <= 1'b0;
      end else begin
         if (pop)              addr_q <= addr_q + ADDR_W'(1);
         if (accept && !legal) err_q  <= 1'b1;
      end
   end

   assign bus.in_ready = ~full;
   assign bus.im_we    = ~empty;
   assign bus.im_addr  = addr_q;
   assign err          = err_q;
endmodule
